cmd_master: RTL and testbench
=============================

// Module: cmd_master
// PURPOSE
// Host-side initiator for the UART register-access byte protocol; the counterpart of the device-side command interpreter.
// Takes one register read/write request, serialises it into command bytes on a UART transmitter and, for reads, collects the reply byte.
// Sits between a test/host controller and a uart instance (transmit/tx_byte/is_transmitting, received/rx_byte/recv_error).
// Protocol: byte0 = {wr, addr[6:0]}. Write adds byte1 = wdata and gets no reply. Read gets one reply byte = rdata.
// PARAMETERS
// TIMEOUT_CYCLES  1_000_000  clk cycles allowed in WAIT_RSP before a read is declared failed (>=2)
// TO_W            $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived, do not override)
// PORTS
// clk_i          in   1  master clock
// rst_n_i        in   1  asynchronous active-low reset
// req_valid_i    in   1  request present
// req_ready_o    out  1  high only in IDLE; request accepted when valid&&ready
// req_wr_i       in   1  1=write, 0=read
// req_addr_i     in   7  register address
// req_wdata_i    in   8  write data (ignored for reads)
// rsp_valid_o    out  1  one-cycle pulse: transaction finished
// rsp_rdata_o    out  8  read data, valid with rsp_valid_o (0 for writes and errors)
// rsp_err_o      out  1  with rsp_valid_o: 1 = timeout or recv_error on reply
// tx_start_o     out  1  one-cycle pulse to uart transmit
// tx_byte_o      out  8  byte to uart tx_byte; held stable from pulse until busy falls
// tx_busy_i      in   1  uart is_transmitting
// rx_valid_i     in   1  uart received (1-cycle pulse)
// rx_byte_i      in   8  uart rx_byte
// rx_error_i     in   1  uart recv_error (1-cycle pulse)
// BEHAVIOUR
// Reset: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, tx_start_o=0, tx_byte_o=0, counters=0.
// Accept: in IDLE, valid&&ready latches wr/addr/wdata; next cycle enters SEND_CMD.
// SEND_CMD: tx_byte_o={wr,addr}, tx_start_o=1 for exactly 1 cycle -> WAIT_CMD.
// WAIT_CMD: wait until tx_busy_i seen high (seen flag), then low -> SEND_DATA if write, else WAIT_RSP.
//   Busy rising 1+ cycles after the pulse is legal; the seen flag prevents a premature exit.
// SEND_DATA / WAIT_DATA: same as above with tx_byte_o=wdata; WAIT_DATA exit -> DONE (rdata=0, err=0).
// WAIT_RSP: timeout counter starts at 0 on entry and increments each cycle.
//   rx_valid_i -> capture rx_byte_i, err=0 -> DONE. rx_error_i -> err=1, rdata=0 -> DONE.
//   Both in same cycle: error wins.
//   Counter reaching TIMEOUT_CYCLES-1 without reply -> err=1 -> DONE.
//   A reply in the expiry cycle is accepted (reply wins over timeout).
// DONE: rsp_valid_o=1 for 1 cycle -> IDLE. rsp_rdata_o/rsp_err_o hold until the next DONE.
// rx_valid_i/rx_error_i outside WAIT_RSP: ignored, no state change.
// req_valid_i outside IDLE: ignored (ready=0); no queueing.
// Latency: write = 2 UART frames + 3 cycles. Read = 1 frame + reply arrival + 2 cycles.
// Reset mid-transaction: immediate return to IDLE, no rsp pulse. Any frame already in the UART is not cancelled.
// STRUCTURE
// cmd_pkg (shared with the device-side interpreter): CMD_WR_BIT=7, CMD_ADDR_W=7, CMD_DATA_W=8, cmd_master_state_e enum
//   (IDLE, SEND_CMD, WAIT_CMD, SEND_DATA, WAIT_DATA, WAIT_RSP, DONE).
// One natural sub-module: cmd_tx_hs (pulse tx_start, track busy-seen/busy-fall, report byte_done); instantiated once, reused for both bytes.
// Timeout counter and FSM live in cmd_master.
// TESTING
// Write addr=0x05 data=0xA7 -> bytes 0x85,0xA7 on tx line; rsp_valid 1 cycle, err=0, rdata=0x00.
// Read addr=0x12, responder replies 0x3C -> tx byte 0x12, rsp_rdata=0x3C, err=0.
// Read with no reply, TIMEOUT_CYCLES=100 -> rsp_valid exactly 100 cycles after WAIT_RSP entry, err=1, rdata=0.
// Read, reply with recv_error pulse -> err=1, rdata=0; a later stray rx byte in IDLE causes no rsp.
// Busy delayed 3 cycles after tx_start -> no early exit; still exactly one pulse per byte.
// Reset asserted in WAIT_DATA -> all outputs reset values, ready=1; a following read completes normally.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the UART register-access byte protocol, used by both
// the host-side initiator and the device-side command interpreter.
package cmd_pkg;

  localparam int CMD_WR_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam int CMD_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_CMD,
    SEND_DATA,
    WAIT_DATA,
    WAIT_RSP,
    DONE
  } cmd_master_state_e;

  // Command byte: write flag in the MSB, register address below it.
  function automatic logic [CMD_DATA_W-1:0] cmd_byte(input logic wr,
                                                     input logic [CMD_ADDR_W-1:0] addr);
    logic [CMD_DATA_W-1:0] b;
    b = '0;
    b[CMD_WR_BIT]             = wr;
    b[CMD_ADDR_W-1:0]         = addr;
    return b;
  endfunction

endpackage

// File: rtl/cmd_tx_hs.sv
// Transmit handshake with the UART: forwards the start pulse and reports when
// the byte has left, i.e. busy was seen high and has since dropped.
module cmd_tx_hs (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic send_i,
  input  logic busy_i,
  output logic tx_start_o,
  output logic byte_done_o
);

  logic r_seen;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_seen <= 1'b0;
    end else if (send_i) begin
      r_seen <= 1'b0;
    end else if (busy_i) begin
      r_seen <= 1'b1;
    end
  end

  // Busy may rise several cycles after the start pulse; without the seen flag
  // the idle gap before busy would look like a finished byte.
  assign tx_start_o  = send_i;
  assign byte_done_o = r_seen & ~busy_i;

endmodule

// File: rtl/cmd_master.sv
// Host-side initiator: serialises one register read/write into command bytes on
// a UART transmitter and, for reads, collects the single reply byte.
module cmd_master
  import cmd_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 1_000_000,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [CMD_ADDR_W-1:0] req_addr_i,
  input  logic [CMD_DATA_W-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [CMD_DATA_W-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  tx_start_o,
  output logic [CMD_DATA_W-1:0] tx_byte_o,
  input  logic                  tx_busy_i,
  input  logic                  rx_valid_i,
  input  logic [CMD_DATA_W-1:0] rx_byte_i,
  input  logic                  rx_error_i
);

  cmd_master_state_e     r_state, w_next_state;
  logic                  r_wr;
  logic [CMD_DATA_W-1:0] r_wdata;
  logic [CMD_DATA_W-1:0] r_tx_byte;
  logic [CMD_DATA_W-1:0] r_rdata;
  logic                  r_err;
  logic [TO_W-1:0]       r_to_cnt;

  logic                  w_accept;
  logic                  w_send;
  logic                  w_byte_done;
  logic                  w_load_data;
  logic                  w_load_rsp;
  logic [CMD_DATA_W-1:0] w_rsp_rdata;
  logic                  w_rsp_err;
  logic                  w_timeout;

  cmd_tx_hs u_tx_hs (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .send_i      (w_send),
    .busy_i      (tx_busy_i),
    .tx_start_o  (tx_start_o),
    .byte_done_o (w_byte_done)
  );

  assign w_accept  = req_valid_i && (r_state == IDLE);
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statement leaves it unassigned and infers a latch.
    w_next_state = r_state;
    w_send       = 1'b0;
    w_load_data  = 1'b0;
    w_load_rsp   = 1'b0;
    w_rsp_rdata  = '0;
    w_rsp_err    = 1'b0;
    case (r_state)
      IDLE:      if (req_valid_i) w_next_state = SEND_CMD;
      SEND_CMD: begin
        w_send       = 1'b1;
        w_next_state = WAIT_CMD;
      end
      WAIT_CMD: if (w_byte_done) begin
        w_load_data  = r_wr;
        w_next_state = r_wr ? SEND_DATA : WAIT_RSP;
      end
      SEND_DATA: begin
        w_send       = 1'b1;
        w_next_state = WAIT_DATA;
      end
      WAIT_DATA: if (w_byte_done) begin
        w_load_rsp   = 1'b1;
        w_next_state = DONE;
      end
      WAIT_RSP: begin
        // Error beats a simultaneous byte; any reply beats the timeout.
        if (rx_error_i) begin
          w_load_rsp   = 1'b1;
          w_rsp_err    = 1'b1;
          w_next_state = DONE;
        end else if (rx_valid_i) begin
          w_load_rsp   = 1'b1;
          w_rsp_rdata  = rx_byte_i;
          w_next_state = DONE;
        end else if (w_timeout) begin
          w_load_rsp   = 1'b1;
          w_rsp_err    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE:      w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_tx_byte <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_wr      <= req_wr_i;
        r_wdata   <= req_wdata_i;
        r_tx_byte <= cmd_byte(req_wr_i, req_addr_i);
      end else if (w_load_data) begin
        r_tx_byte <= r_wdata;
      end
      if (w_load_rsp) begin
        r_rdata <= w_rsp_rdata;
        r_err   <= w_rsp_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_to_cnt <= '0;
    end else if (r_state != WAIT_RSP) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == DONE);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign tx_byte_o   = r_tx_byte;

endmodule

// File: tb/tb_cmd_master.sv
// Self-checking bench for cmd_master: a behavioural UART/responder drives the
// master and a transaction-level model predicts bytes, responses and timing.
module tb_cmd_master;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_wr;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       tx_start, tx_busy;
  logic [7:0] tx_byte;
  logic       rx_valid, rx_error;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int tx_pulses = 0;
  int exp_tx    = 0;
  int rsp_cnt   = 0;
  int last_cyc  = 0;
  logic [7:0] last_rdata = '0;
  logic       last_err   = 1'b0;

  cmd_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .tx_start_o  (tx_start),
    .tx_byte_o   (tx_byte),
    .tx_busy_i   (tx_busy),
    .rx_valid_i  (rx_valid),
    .rx_byte_i   (rx_byte),
    .rx_error_i  (rx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) tx_pulses++;
    if (rsp_valid) begin
      rsp_cnt++;
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
      last_cyc   = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART side of one byte: wait for the start pulse, optionally delay busy,
  // hold busy for a frame, then drop it. Returns the cycle of the busy fall.
  task automatic run_byte(input logic [7:0] exp_byte, input int bd, input int flen,
                          input bit stray, output int drop_cyc);
    logic [7:0] b;
    bit ok;
    ok = 1'b0;
    b  = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_start) begin
        b  = tx_byte;
        ok = 1'b1;
        break;
      end
    end
    check("tx_start seen", 32'(ok), 32'd1);
    check("tx_byte", 32'(b), 32'(exp_byte));
    exp_tx++;
    repeat (bd) @(negedge clk);
    tx_busy = 1'b1;
    for (int i = 0; i < flen; i++) begin
      @(negedge clk);
      rx_valid = (stray && i == 1);
    end
    rx_valid = 1'b0;
    check("tx_byte hold", 32'(tx_byte), 32'(exp_byte));
    tx_busy  = 1'b0;
    drop_cyc = cyc;
  endtask

  // kind: 0 no reply, 1 byte, 2 recv_error, 3 byte+error same cycle.
  // j: reply arrives j cycles after the command byte's busy fall.
  task automatic do_txn(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                        input int kind, input int j, input int bd, input bit stray);
    int c0, d1, d2, t, k, exp_cyc;
    logic [7:0] rbyte, exp_rdata;
    logic       exp_err;
    c0    = rsp_cnt;
    rbyte = 8'($urandom);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = 7'($urandom);
    check("ready low when busy", 32'(req_ready), 32'd0);
    run_byte({wr, addr}, bd, $urandom_range(3, 8), stray, d1);
    if (wr) begin
      run_byte(wdata, bd, $urandom_range(3, 8), stray, d2);
      exp_rdata = 8'h00;
      exp_err   = 1'b0;
      exp_cyc   = d2 + 1;
    end else begin
      if (kind != 0 && j <= T) begin
        t         = j;
        exp_err   = (kind != 1);
        exp_rdata = (kind == 1) ? rbyte : 8'h00;
      end else begin
        t         = T;
        exp_err   = 1'b1;
        exp_rdata = 8'h00;
      end
      exp_cyc = d1 + 1 + t;
      if (kind != 0) begin
        repeat (j) @(negedge clk);
        rx_byte  = rbyte;
        rx_valid = (kind == 1 || kind == 3);
        rx_error = (kind == 2 || kind == 3);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
      end
    end
    k = 0;
    while (rsp_cnt == c0 && k < T + 50) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("rsp pulse count", 32'(rsp_cnt - c0), 32'd1);
    check("rsp rdata", 32'(last_rdata), 32'(exp_rdata));
    check("rsp err", 32'(last_err), 32'(exp_err));
    check("rsp latency", 32'(last_cyc), 32'(exp_cyc));
    check("tx pulse total", 32'(tx_pulses), 32'(exp_tx));
    check("ready back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int c0, d;
    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_byte = '0;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rdata", 32'(rsp_rdata), 32'd0);
    check("reset err", 32'(rsp_err), 32'd0);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset tx_byte", 32'(tx_byte), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_txn(1'b1, 7'h05, 8'hA7, 0, 0, 1, 1'b0);
    do_txn(1'b0, 7'h12, 8'h00, 1, 4, 1, 1'b0);
    do_txn(1'b0, 7'h33, 8'h00, 0, 0, 2, 1'b0);
    do_txn(1'b0, 7'h40, 8'h00, 2, 5, 1, 1'b0);
    c0 = rsp_cnt;
    rx_byte = 8'h5A; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("stray rx in idle", 32'(rsp_cnt - c0), 32'd0);
    do_txn(1'b1, 7'h7F, 8'h3C, 0, 0, 3, 1'b1);
    do_txn(1'b0, 7'h01, 8'h00, 3, 2, 1, 1'b0);
    do_txn(1'b0, 7'h02, 8'h00, 1, T, 1, 1'b0);
    do_txn(1'b0, 7'h03, 8'h00, 1, T + 1, 2, 1'b0);

    // Reset while the data byte is on the line.
    c0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 7'h2A; req_wdata = 8'hC3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    run_byte(8'hAA, 1, 4, 1'b0, d);
    run_byte(8'hC3, 1, 2, 1'b0, d);
    tx_busy = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset ready", 32'(req_ready), 32'd1);
    check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset rdata", 32'(rsp_rdata), 32'd0);
    check("midreset err", 32'(rsp_err), 32'd0);
    check("midreset tx_start", 32'(tx_start), 32'd0);
    check("midreset tx_byte", 32'(tx_byte), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    repeat (5) @(negedge clk);
    check("midreset no rsp", 32'(rsp_cnt - c0), 32'd0);
    check("midreset tx pulses", 32'(tx_pulses), 32'(exp_tx));
    do_txn(1'b0, 7'h12, 8'h00, 1, 3, 1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int kind, j;
      kind = $urandom_range(0, 3);
      j = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(1, 20);
      do_txn(1'($urandom), 7'($urandom), 8'($urandom), kind, j,
             $urandom_range(1, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
